// File: rtl/mode_alu_seq_pkg.sv
// Shared types for the sequential four-mode ALU: operation select codes and FSM states.
package mode_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD_DBL  = 2'b00,
        MODE_SUB_DIV  = 2'b01,
        MODE_SHIFT_OR = 2'b10,
        MODE_XNOR_NEG = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mode_alu_seq_if.sv
// Operand/result bundle of mode_alu_seq; slave is the ALU side, master the producer/consumer side.
interface mode_alu_seq_if #(
    parameter int WIDTH = 32
) ();

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // Producers hold valid and data stable until ready; a held result stays stable until taken.
    logic                  p_in_valid;
    logic                  p_in_ready;
    logic [1:0]            p_mode;
    logic [WIDTH-1:0]      p_in1;
    logic [WIDTH-1:0]      p_in2;
    logic [WIDTH-1:0]      p_div;
    logic                  p_out_valid;
    logic                  p_out_ready;
    logic [WIDTH-1:0]      p_out;
    logic [1:0]            p_out_mode;
    logic                  p_div_zero;
    logic                  p_busy;
    mode_alu_pkg::state_e  dbg_state;

    modport slave (
        input  p_in_valid, p_mode, p_in1, p_in2, p_div, p_out_ready,
        output p_in_ready, p_out_valid, p_out, p_out_mode, p_div_zero, p_busy, dbg_state
    );

    modport master (
        output p_in_valid, p_mode, p_in1, p_in2, p_div, p_out_ready,
        input  p_in_ready, p_out_valid, p_out, p_out_mode, p_div_zero, p_busy, dbg_state
    );

endinterface

// File: rtl/mode_alu_seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (start_i) begin
            cnt_d = CW'(WIDTH);
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (cnt_q != '0) begin
            // A set top bit of the trial difference means the subtraction went negative: restore.
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    // Done flags the final step so the owner can capture the finished quotient at the same edge.
    assign done_o     = (cnt_q == CW'(1));
    assign quotient_o = quo_d;

endmodule

// File: rtl/mode_alu_seq.sv
// Handshaked four-mode ALU: single-cycle add/shift/negate modes plus a multi-cycle subtract-divide.
module mode_alu_seq
    import mode_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHL   = 4,
    parameter int SHR   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mode_alu_seq_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       out_mode_q, out_mode_d;
    logic             div_zero_q, div_zero_d;
    logic             accept;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sum;
    mode_e            mode_in;

    assign mode_in = mode_e'(bus.p_mode);
    assign accept  = bus.p_in_valid && (state_q == IDLE);
    assign diff    = bus.p_in1 - bus.p_in2;
    assign sum     = bus.p_in1 + bus.p_in2;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (diff),
        .divisor_i  (bus.p_div),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        out_mode_d = out_mode_q;
        div_zero_d = div_zero_q;
        div_start  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = DONE;
                    out_mode_d = bus.p_mode;
                    div_zero_d = 1'b0;
                    unique case (mode_in)
                        MODE_ADD_DBL:  out_d = sum << 1;
                        MODE_SHIFT_OR: out_d = (bus.p_in1 << SHL) | (bus.p_in2 >> SHR);
                        MODE_XNOR_NEG: out_d = ~(bus.p_in1 ^ bus.p_in2) + WIDTH'(1);
                        MODE_SUB_DIV: begin
                            if (bus.p_div == '0) begin
                                out_d      = '1;
                                div_zero_d = 1'b1;
                            end else begin
                                // Result fields keep the previous result until the quotient lands.
                                state_d    = DIV;
                                out_d      = out_q;
                                out_mode_d = out_mode_q;
                                div_zero_d = div_zero_q;
                                div_start  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d    = DONE;
                    out_d      = quotient;
                    out_mode_d = MODE_SUB_DIV;
                    div_zero_d = 1'b0;
                end
            end
            DONE: begin
                if (bus.p_out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_q      <= '0;
            out_mode_q <= 2'b00;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            out_mode_q <= out_mode_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.p_in_ready  = (state_q == IDLE);
    assign bus.p_out_valid = (state_q == DONE);
    assign bus.p_busy      = (state_q != IDLE);
    assign bus.p_out       = out_q;
    assign bus.p_out_mode  = out_mode_q;
    assign bus.p_div_zero  = div_zero_q;
    assign bus.dbg_state   = state_q;

endmodule
